// File: rtl/mem_port_arbiter.sv
// Shares one memory port between the instruction-fetch and data-memory sides.
// The data side has priority; a starvation counter forces an I grant after STARVE_LIMIT D grants.
module mem_port_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_read,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_resp,
  input  logic        d_read,
  input  logic        d_write,
  input  logic [3:0]  d_mbe,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_resp,
  output logic        mem_read,
  output logic        mem_write,
  output logic [3:0]  mem_mbe,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_resp
);

  // state  | meaning
  // IDLE   | arbitrate between I and D requests
  // I_BUSY | instruction read on the memory port, waiting for mem_resp
  // D_BUSY | data read/write on the memory port, waiting for mem_resp
  // I_DONE | i_resp pulse, then back to IDLE
  // D_DONE | d_resp pulse, then back to IDLE
  typedef enum logic [2:0] {IDLE, I_BUSY, D_BUSY, I_DONE, D_DONE} state_t;

  localparam int CW = (STARVE_LIMIT < 2) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  state_t          state_q;
  logic [CW-1:0]   starve_q;
  logic [CW-1:0]   starve_d;
  logic            mem_read_q, mem_write_q;
  logic [3:0]      mem_mbe_q;
  logic [31:0]     mem_addr_q, mem_wdata_q;
  logic [31:0]     i_rdata_q, d_rdata_q;
  logic            i_resp_q, d_resp_q;
  logic            dreq, force_i, grant_d;

  assign dreq    = d_read | d_write;
  assign force_i = i_read && (STARVE_LIMIT != 0) && (starve_q == LIMIT);
  assign grant_d = dreq && !force_i;

  // Counter value to load on a D grant; saturates so a long I stall cannot wrap it.
  always_comb begin
    starve_d = '0;
    if (i_read) starve_d = (starve_q == LIMIT) ? starve_q : starve_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      starve_q    <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_mbe_q   <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
      i_resp_q    <= 1'b0;
      d_resp_q    <= 1'b0;
    end else begin
      i_resp_q <= 1'b0;
      d_resp_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grant_d) begin
            state_q     <= D_BUSY;
            starve_q    <= starve_d;
            mem_write_q <= d_write;
            mem_read_q  <= !d_write;
            mem_mbe_q   <= d_mbe;
            mem_addr_q  <= d_addr;
            mem_wdata_q <= d_wdata;
          end else if (i_read) begin
            state_q     <= I_BUSY;
            starve_q    <= '0;
            mem_read_q  <= 1'b1;
            mem_write_q <= 1'b0;
            mem_mbe_q   <= 4'b1111;
            mem_addr_q  <= i_addr;
            mem_wdata_q <= '0;
          end
        end
        I_BUSY: begin
          if (mem_resp) begin
            state_q    <= I_DONE;
            mem_read_q <= 1'b0;
            i_rdata_q  <= mem_rdata;
            i_resp_q   <= 1'b1;
          end
        end
        D_BUSY: begin
          if (mem_resp) begin
            state_q     <= D_DONE;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            d_rdata_q   <= mem_rdata;
            d_resp_q    <= 1'b1;
          end
        end
        I_DONE, D_DONE: state_q <= IDLE;
        default:        state_q <= IDLE;
      endcase
    end
  end

  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign mem_mbe   = mem_mbe_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign i_rdata   = i_rdata_q;
  assign i_resp    = i_resp_q;
  assign d_rdata   = d_rdata_q;
  assign d_resp    = d_resp_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (STARVE_LIMIT=2) with a latency-programmable memory responder.
module tb_mem_port_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        i_read, d_read, d_write;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic [3:0]  d_mbe;
  logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata;
  logic        i_resp, d_resp, mem_read, mem_write;
  logic [3:0]  mem_mbe;
  logic [31:0] mem_rdata = 32'h0;
  logic        auto_resp = 1'b0, man_resp = 1'b0;
  logic        mem_resp;

  int          n_tests = 0, n_fail = 0;
  int          lat = 1;
  bit          auto_mem = 1'b0;
  logic [31:0] grants[$];
  int          i_cnt = 0, d_cnt = 0, rcnt = 0;
  bit          both_seen = 1'b0, strobe_prev = 1'b0;

  assign mem_resp = auto_resp | man_resp;
  always #5 clk = ~clk;

  mem_port_arbiter #(.STARVE_LIMIT(2)) dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_mbe(d_mbe), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_rdata(d_rdata), .d_resp(d_resp),
    .mem_read(mem_read), .mem_write(mem_write), .mem_mbe(mem_mbe),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_resp(mem_resp)
  );

  function automatic logic [31:0] mem_model(input logic [31:0] a);
    return (a == 32'h60) ? 32'h0000_0013 : ~a;
  endfunction

  // Grant / response logger
  always @(posedge clk) begin
    #1;
    if ((mem_read === 1'b1 || mem_write === 1'b1) && !strobe_prev) grants.push_back(mem_addr);
    strobe_prev = (mem_read === 1'b1) || (mem_write === 1'b1);
    if (i_resp === 1'b1) i_cnt++;
    if (d_resp === 1'b1) d_cnt++;
    if (i_resp === 1'b1 && d_resp === 1'b1) both_seen = 1'b1;
  end

  // Memory responder: mem_resp after lat cycles of strobe
  always @(posedge clk) begin
    #2;
    if (!auto_mem) begin
      auto_resp = 1'b0;
      rcnt = 0;
    end else if (auto_resp) begin
      auto_resp = 1'b0;
      rcnt = 0;
    end else if (mem_read === 1'b1 || mem_write === 1'b1) begin
      if (rcnt >= lat - 1) begin
        auto_resp = 1'b1;
        mem_rdata = mem_model(mem_addr);
      end else rcnt++;
    end else rcnt = 0;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_resp(input bit side_d, output int cyc);
    bit got = 1'b0;
    cyc = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      cyc++;
      if ((side_d ? d_resp : i_resp) === 1'b1) got = 1'b1;
    end
    check(side_d ? "d_resp_timeout" : "i_resp_timeout", {31'b0, got}, 32'd1);
  endtask

  initial begin
    int base, i0, d0, c1, c2;
    logic [31:0] exp_order [6] = '{32'h300, 32'h300, 32'h400, 32'h300, 32'h300, 32'h400};

    rst = 1'b0; i_read = 0; d_read = 0; d_write = 0;
    i_addr = 0; d_addr = 0; d_wdata = 0; d_mbe = 0;
    step(2);
    check("rst_strobes_resp", {i_resp, d_resp, mem_read, mem_write}, 4'b0000);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata_mbe", {mem_wdata, mem_mbe}, 36'h0);
    check("rst_rdata", i_rdata | d_rdata, 32'h0);
    rst = 1'b1; auto_mem = 1'b1; lat = 2;
    step(1);

    // Single I read, 2-cycle memory
    i_read = 1; i_addr = 32'h60;
    step(1);
    check("t1_busy1_strobes", {mem_read, mem_write, i_resp}, 3'b100);
    check("t1_busy1_addr", mem_addr, 32'h60);
    check("t1_busy1_mbe_wdata", {mem_mbe, mem_wdata}, {4'hF, 32'h0});
    step(1);
    check("t1_busy2_read", mem_read, 1'b1);
    check("t1_busy2_addr", mem_addr, 32'h60);
    step(1);
    check("t1_done_resp", {i_resp, d_resp, mem_read}, 3'b100);
    check("t1_done_rdata", i_rdata, 32'h0000_0013);
    i_read = 0;
    step(1);
    check("t1_idle_resp", i_resp, 1'b0);

    // D byte write, requester drops mid-BUSY
    d0 = d_cnt;
    d_write = 1; d_addr = 32'h1003; d_mbe = 4'b1000; d_wdata = 32'hAB00_0000;
    step(1);
    check("t2_busy1_strobes", {mem_write, mem_read}, 2'b10);
    check("t2_busy1_addr", mem_addr, 32'h1003);
    check("t2_busy1_mbe", mem_mbe, 4'b1000);
    check("t2_busy1_wdata", mem_wdata, 32'hAB00_0000);
    d_write = 0; d_addr = 32'hFFFF_FFFF; d_wdata = 32'h0; d_mbe = 4'h0;
    step(1);
    check("t2_busy2_stable", {mem_write, mem_read, mem_mbe, mem_addr, mem_wdata},
          {1'b1, 1'b0, 4'b1000, 32'h1003, 32'hAB00_0000});
    step(1);
    check("t2_done_resp", {d_resp, i_resp, mem_write}, 3'b100);
    step(2);
    check("t2_resp_count", d_cnt - d0, 32'd1);

    // Simultaneous I and D, 1-cycle memory
    lat = 1;
    i_read = 1; i_addr = 32'h100; d_read = 1; d_addr = 32'h200;
    step(1);
    check("t3_d_first_addr", {mem_read, mem_addr}, {1'b1, 32'h200});
    step(1);
    check("t3_d_resp", {d_resp, i_resp}, 2'b10);
    check("t3_d_rdata", d_rdata, 32'hFFFF_FDFF);
    d_read = 0;
    step(1);
    check("t3_turnaround", {mem_read, mem_write, i_resp, d_resp}, 4'b0000);
    step(1);
    check("t3_i_addr", {mem_read, mem_addr}, {1'b1, 32'h100});
    step(1);
    check("t3_i_resp", {i_resp, d_resp}, 2'b10);
    check("t3_i_rdata", i_rdata, 32'hFFFF_FEFF);
    i_read = 0;
    step(1);
    check("t3_end_idle", {i_resp, mem_read}, 2'b00);

    // Starvation with limit 2: D, D, I, D, D, I
    base = grants.size(); i0 = i_cnt; d0 = d_cnt;
    i_read = 1; i_addr = 32'h400; d_read = 1; d_addr = 32'h300;
    step(18);
    i_read = 0; d_read = 0;
    step(3);
    check("t4_grant_count", grants.size() - base, 32'd6);
    for (int k = 0; k < 6; k++)
      check($sformatf("t4_grant%0d", k), grants[base + k], exp_order[k]);
    check("t4_i_resps", i_cnt - i0, 32'd2);
    check("t4_d_resps", d_cnt - d0, 32'd4);

    // Reset during D_BUSY, stale mem_resp afterwards
    auto_mem = 1'b0;
    d_read = 1; d_addr = 32'h500;
    step(1);
    check("t5_busy", {mem_read, mem_addr}, {1'b1, 32'h500});
    rst = 1'b0; d_read = 0;
    step(1);
    check("t5_rst_strobes_resp", {i_resp, d_resp, mem_read, mem_write}, 4'b0000);
    check("t5_rst_addr_wdata", mem_addr | mem_wdata, 32'h0);
    check("t5_rst_mbe", mem_mbe, 4'h0);
    check("t5_rst_rdata", i_rdata | d_rdata, 32'h0);
    rst = 1'b1; man_resp = 1'b1;
    step(1);
    check("t5_stale_cycle", {i_resp, d_resp, mem_read, mem_write}, 4'b0000);
    man_resp = 1'b0;
    step(1);
    check("t5_stale_noresp", {i_resp, d_resp}, 2'b00);
    check("t5_stale_rdata", d_rdata, 32'h0);
    auto_mem = 1'b1; lat = 1;

    // Back-to-back I reads
    base = grants.size();
    i_read = 1; i_addr = 32'h0;
    wait_resp(1'b0, c1);
    check("t6_first_latency", c1, 32'd2);
    check("t6_first_rdata", i_rdata, 32'hFFFF_FFFF);
    check("t6_one_grant_before_resp", grants.size() - base, 32'd1);
    i_addr = 32'h4;
    wait_resp(1'b0, c2);
    check("t6_resp_spacing", c2, 32'd3);
    check("t6_second_rdata", i_rdata, 32'hFFFF_FFFB);
    i_read = 0;
    step(2);
    check("t6_grant_addr0", grants[base], 32'h0);
    check("t6_grant_addr1", grants[base + 1], 32'h4);
    check("t6_grant_count", grants.size() - base, 32'd2);

    check("never_both_resp", {31'b0, both_seen}, 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
